// File: rtl/clk_mux_ctrl_if.sv
// clk_mux_ctrl_if
//   Groups the request handshake, the clock-alive status, the mux select and the
//   status pulses of the clock-mux sequencer.
//   master : requester / monitor side. Drives the request, the alive flags and
//            auto_en_i. Observes ready, the selects and the status pulses.
//   slave  : the sequencer (clk_mux_ctrl).
//   Signal names keep their original _i/_o suffixes, so they still read from the
//   sequencer's point of view.
interface clk_mux_ctrl_if;
  logic req_valid_i;
  logic req_sel_i;
  logic req_ready_o;
  logic clk0_alive_i;
  logic clk1_alive_i;
  logic auto_en_i;
  logic sel_o;
  logic cur_sel_o;
  logic busy_o;
  logic done_o;
  logic err_o;
  logic failover_o;

  modport master (
    output req_valid_i, req_sel_i, clk0_alive_i, clk1_alive_i, auto_en_i,
    input  req_ready_o, sel_o, cur_sel_o, busy_o, done_o, err_o, failover_o
  );

  modport slave (
    input  req_valid_i, req_sel_i, clk0_alive_i, clk1_alive_i, auto_en_i,
    output req_ready_o, sel_o, cur_sel_o, busy_o, done_o, err_o, failover_o
  );
endinterface

// File: rtl/clk_mux_ctrl.sv
// clk_mux_ctrl
//   Sequencer for a glitch-free 2:1 clock mux. It runs on the always-on control
//   clock and owns the mux select. Switch requests arrive over a valid/ready
//   handshake, and a request for a clock that is not running is rejected. After
//   sel_o changes, the block stays busy for SETTLE_CYCLES so that the mux
//   synchronizers can hand over. If auto_en_i is set and the active clock has
//   been dead for FAIL_CYCLES cycles, the block fails over to the other clock.
// Ports
//   clk_i   : always-on control clock, rising edge
//   srst_i  : synchronous reset, active high
//   bus     : clk_mux_ctrl_if.slave
//             request  : req_valid_i, req_sel_i, req_ready_o (combinational)
//             status   : clk0_alive_i, clk1_alive_i (already synchronized), auto_en_i
//             mux      : sel_o (live select), cur_sel_o (committed select)
//             pulses   : done_o, err_o, failover_o (one cycle each), busy_o (SETTLE)
module clk_mux_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned FAIL_CYCLES   = 8
) (
  input logic           clk_i,
  input logic           srst_i,
  clk_mux_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned FC_W  = $clog2(FAIL_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [FC_W-1:0]  FAIL_MAX    = FC_W'(FAIL_CYCLES);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [FC_W-1:0]  fail_cnt;
  logic             auto_q;
  logic             sel_q;
  logic             cur_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             fo_q;

  logic alive_cur;
  logic alive_oth;
  logic alive_tgt;
  logic fail_trig;
  logic ready;
  logic accept;

  always_comb begin
    alive_cur = cur_q ? bus.clk1_alive_i : bus.clk0_alive_i;
    alive_oth = cur_q ? bus.clk0_alive_i : bus.clk1_alive_i;
    alive_tgt = bus.req_sel_i ? bus.clk1_alive_i : bus.clk0_alive_i;
    fail_trig = (state == IDLE) & bus.auto_en_i & (fail_cnt == FAIL_MAX) & alive_oth;
    ready     = (state == IDLE) & ~fail_trig & ~srst_i;
    accept    = bus.req_valid_i & ready;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      fail_cnt <= '0;
      auto_q   <= 1'b0;
      sel_q    <= 1'b0;
      cur_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fo_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      fo_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (fail_trig) begin
            // Failover wins over any request presented in the same cycle.
            // The request sees ready low, so it is not accepted.
            sel_q    <= ~cur_q;
            auto_q   <= 1'b1;
            cnt      <= SETTLE_LOAD;
            fail_cnt <= '0;
            busy_q   <= 1'b1;
            state    <= SETTLE;
          end else begin
            if (bus.auto_en_i && !alive_cur) begin
              if (fail_cnt != FAIL_MAX) fail_cnt <= fail_cnt + 1'b1;
            end else begin
              fail_cnt <= '0;
            end
            if (accept) begin
              if (bus.req_sel_i == cur_q) begin
                done_q <= 1'b1;
              end else if (!alive_tgt) begin
                err_q <= 1'b1;
              end else begin
                sel_q    <= bus.req_sel_i;
                auto_q   <= 1'b0;
                cnt      <= SETTLE_LOAD;
                fail_cnt <= '0;
                busy_q   <= 1'b1;
                state    <= SETTLE;
              end
            end
          end
        end
        SETTLE: begin
          // Changes in the alive flags do not abort a switch in progress.
          if (cnt == '0) begin
            cur_q  <= sel_q;
            done_q <= ~auto_q;
            fo_q   <= auto_q;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.sel_o       = sel_q;
  assign bus.cur_sel_o   = cur_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.failover_o  = fo_q;

endmodule

// File: tb/tb_clk_mux_ctrl.sv
// tb_clk_mux_ctrl
//   Directed bench for clk_mux_ctrl with SETTLE_CYCLES=16 and FAIL_CYCLES=8.
//   A vector table covers the single-cycle behaviour. Hand-written sequences
//   cover the switch, failover and reset-abort timing.
module tb_clk_mux_ctrl;

  logic clk;
  logic srst;

  clk_mux_ctrl_if bus ();

  clk_mux_ctrl #(
    .SETTLE_CYCLES (16),
    .FAIL_CYCLES   (8)
  ) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic srst, valid, rsel, a0, a1, aen;
    logic e_ready, e_sel, e_cur, e_busy, e_done, e_err, e_fo;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic c, input logic b,
                         input logic d, input logic e, input logic f);
    chk($sformatf("%s sel_o", tag),      bus.sel_o,      s);
    chk($sformatf("%s cur_sel_o", tag),  bus.cur_sel_o,  c);
    chk($sformatf("%s busy_o", tag),     bus.busy_o,     b);
    chk($sformatf("%s done_o", tag),     bus.done_o,     d);
    chk($sformatf("%s err_o", tag),      bus.err_o,      e);
    chk($sformatf("%s failover_o", tag), bus.failover_o, f);
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    #1;
    chk($sformatf("%s req_ready_o", tag), bus.req_ready_o, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call this right after the edge that entered SETTLE. It steps to the commit
  // edge, which comes 16 edges after entry.
  task automatic finish_settle(input string tag, input logic tgt, input logic is_auto);
    for (int i = 1; i < 16; i++) begin
      step();
      chk_out($sformatf("%s settle%0d", tag, i), tgt, ~tgt, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_ready($sformatf("%s settle%0d", tag, i), 1'b0);
    end
    step();
    chk_out($sformatf("%s commit", tag), tgt, tgt, 1'b0, ~is_auto, 1'b0, is_auto);
  endtask

  task automatic switch_to(input string tag, input logic tgt);
    bus.req_valid_i = 1'b1;
    bus.req_sel_i   = tgt;
    chk_ready($sformatf("%s req", tag), 1'b1);
    step();
    bus.req_valid_i = 1'b0;
    chk_out($sformatf("%s accept", tag), tgt, ~tgt, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_settle(tag, tgt, 1'b0);
    chk_ready($sformatf("%s after", tag), 1'b1);
    step();
    chk_out($sformatf("%s post", tag), tgt, tgt, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // At most one status pulse may be high in any cycle.
  always @(negedge clk) begin
    if (!srst)
      chk("onehot pulses", ($countones({bus.done_o, bus.err_o, bus.failover_o}) <= 1), 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    srst             = 1'b1;
    bus.req_valid_i  = 1'b0;
    bus.req_sel_i    = 1'b0;
    bus.clk0_alive_i = 1'b1;
    bus.clk1_alive_i = 1'b1;
    bus.auto_en_i    = 1'b0;

    //            srst valid rsel a0 a1 aen | rdy sel cur busy done err fo
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      srst             = vecs[i].srst;
      bus.req_valid_i  = vecs[i].valid;
      bus.req_sel_i    = vecs[i].rsel;
      bus.clk0_alive_i = vecs[i].a0;
      bus.clk1_alive_i = vecs[i].a1;
      bus.auto_en_i    = vecs[i].aen;
      chk_ready($sformatf("vec%0d", i), vecs[i].e_ready);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_cur, vecs[i].e_busy,
              vecs[i].e_done, vecs[i].e_err, vecs[i].e_fo);
    end
    bus.req_valid_i = 1'b0;
    step();
    chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full switch to clk1 and back to clk0.
    switch_to("sw1", 1'b1);
    switch_to("sw0", 1'b0);

    // Failover: clk0 dead for 8 edges. A no-op request is presented on the trigger cycle.
    bus.auto_en_i    = 1'b1;
    bus.clk0_alive_i = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk_out($sformatf("fo cnt%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_ready($sformatf("fo cnt%0d", i), 1'b1);
    end
    step();
    bus.req_valid_i = 1'b1;
    bus.req_sel_i   = 1'b0;
    chk_ready("fo trig", 1'b0);
    step();
    chk_out("fo enter", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.clk0_alive_i = 1'b1;
    finish_settle("fo", 1'b1, 1'b1);
    // The held request is accepted only now. It is a real switch back to clk0.
    switch_to("fo req", 1'b0);

    // Both clocks dead: fail_cnt saturates and nothing happens until clk1 returns.
    bus.clk0_alive_i = 1'b0;
    bus.clk1_alive_i = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_out($sformatf("dead%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_ready($sformatf("dead%0d", i), 1'b1);
    end
    bus.clk1_alive_i = 1'b1;
    chk_ready("dead revive", 1'b0);
    step();
    chk_out("dead enter", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    finish_settle("dead", 1'b1, 1'b1);
    bus.clk0_alive_i = 1'b1;
    bus.auto_en_i    = 1'b0;
    step();
    switch_to("rst prep", 1'b0);

    // Reset during SETTLE aborts the switch with no pulse.
    bus.req_valid_i = 1'b1;
    bus.req_sel_i   = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    chk_out("rst enter", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    srst = 1'b1;
    chk_ready("rst high", 1'b0);
    step();
    chk_out("rst abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    srst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_out($sformatf("rst quiet%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
